// File: rtl/multicycle_control.sv
// Control FSM for the shared-memory MIPS multicycle datapath: sequences
// R-type, lw, sw, beq and j, stalling FETCH/MEMRD/MEMWR on mem_ready.
module multicycle_control #(
  parameter int OPCODE_WIDTH = 6,
  parameter int STATE_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [OPCODE_WIDTH-1:0] op,
  input  logic                    mem_ready,
  output logic                    PCWrite,
  output logic                    PCWriteCond,
  output logic                    IorD,
  output logic                    MemRead,
  output logic                    MemWrite,
  output logic                    MemtoReg,
  output logic                    IRWrite,
  output logic [1:0]              PCSource,
  output logic [1:0]              ALUOp,
  output logic                    ALUSrcA,
  output logic [1:0]              ALUSrcB,
  output logic                    RegWrite,
  output logic                    RegDst,
  output logic                    instr_done,
  output logic                    illegal_op,
  output logic [STATE_WIDTH-1:0]  state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC    = 4'd6,
    RCOMP   = 4'd7,
    BRANCH  = 4'd8,
    JUMP    = 4'd9,
    ILLEGAL = 4'd10
  } state_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_R   = OPCODE_WIDTH'(6'b000000);
  localparam logic [OPCODE_WIDTH-1:0] OP_LW  = OPCODE_WIDTH'(6'b100011);
  localparam logic [OPCODE_WIDTH-1:0] OP_SW  = OPCODE_WIDTH'(6'b101011);
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ = OPCODE_WIDTH'(6'b000100);
  localparam logic [OPCODE_WIDTH-1:0] OP_J   = OPCODE_WIDTH'(6'b000010);

  state_t state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  assign state = STATE_WIDTH'(state_q);

  // Every output is held low while rst is high so no strobe escapes a reset.
  always_comb begin
    state_d     = FETCH;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    if (!rst) begin
      case (state_q)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
          state_d = mem_ready ? DECODE : FETCH;
        end
        DECODE: begin
          ALUSrcB = 2'b11;
          if (op == OP_LW || op == OP_SW) state_d = MEMADR;
          else if (op == OP_R)            state_d = EXEC;
          else if (op == OP_BEQ)          state_d = BRANCH;
          else if (op == OP_J)            state_d = JUMP;
          else                            state_d = ILLEGAL;
        end
        MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          state_d = (op == OP_LW) ? MEMRD : MEMWR;
        end
        MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          state_d = mem_ready ? MEMWB : MEMRD;
        end
        MEMWB: begin
          RegWrite   = 1'b1;
          MemtoReg   = 1'b1;
          instr_done = 1'b1;
        end
        MEMWR: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = mem_ready;
          state_d    = mem_ready ? FETCH : MEMWR;
        end
        EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
          state_d = RCOMP;
        end
        RCOMP: begin
          RegWrite   = 1'b1;
          RegDst     = 1'b1;
          instr_done = 1'b1;
        end
        BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          instr_done  = 1'b1;
        end
        JUMP: begin
          PCWrite    = 1'b1;
          PCSource   = 2'b10;
          instr_done = 1'b1;
        end
        ILLEGAL: begin
          // PC was already advanced in FETCH; just flag and refetch.
          illegal_op = 1'b1;
        end
        default: state_d = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: each instruction is expanded into
// its per-cycle control trace and compared cycle by cycle against the DUT.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] op = 6'd0;
  logic       mem_ready = 1'b1;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic [1:0] PCSource, ALUOp, ALUSrcB;
  logic       ALUSrcA, RegWrite, RegDst, instr_done, illegal_op;
  logic [3:0] state;

  multicycle_control dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .PCSource(PCSource), .ALUOp(ALUOp),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
    .RegDst(RegDst), .instr_done(instr_done), .illegal_op(illegal_op),
    .state(state)
  );

  // clock / reset
  always #5 clk = ~clk;

  localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_J = 4, K_ILL = 5;

  // Scoreboard: one entry per expected cycle = {state, 18 control bits}.
  logic [21:0] exp_q[$];
  logic        mr_q[$];
  logic [5:0]  op_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [21:0] mk(input int st, input bit pcw, input bit pcwc,
      input bit iord, input bit mrd, input bit mwr, input bit m2r, input bit irw,
      input int pcsrc, input int aluop, input bit srca, input int srcb,
      input bit rw, input bit rdst, input bit done, input bit ill);
    mk = {st[3:0], pcw, pcwc, iord, mrd, mwr, m2r, irw, pcsrc[1:0], aluop[1:0],
          srca, srcb[1:0], rw, rdst, done, ill};
  endfunction

  function automatic logic [17:0] got_ctrl();
    got_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, instr_done, illegal_op};
  endfunction

  function automatic logic [5:0] opcode_of(input int kind);
    logic [5:0] o;
    case (kind)
      K_R:   o = 6'b000000;
      K_LW:  o = 6'b100011;
      K_SW:  o = 6'b101011;
      K_BEQ: o = 6'b000100;
      K_J:   o = 6'b000010;
      default: begin
        o = 6'($urandom_range(0, 63));
        while (o == 6'b000000 || o == 6'b100011 || o == 6'b101011 ||
               o == 6'b000100 || o == 6'b000010)
          o = 6'($urandom_range(0, 63));
      end
    endcase
    opcode_of = o;
  endfunction

  // driver tasks
  task automatic add(input logic [21:0] v, input logic mr, input logic [5:0] o);
    exp_q.push_back(v);
    mr_q.push_back(mr);
    op_q.push_back(o);
  endtask

  function automatic logic rnd_bit();
    rnd_bit = 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] rnd_op();
    rnd_op = 6'($urandom_range(0, 63));
  endfunction

  // Expand one instruction into its cycle trace; op is random except in
  // DECODE and MEMADR, mem_ready is random where it must be ignored.
  task automatic plan(input int kind, input logic [5:0] o, input int fw, input int mw);
    for (int i = 0; i < fw; i++)
      add(mk(0, 0,0,0,1,0,0,0, 0,0,0,1, 0,0,0,0), 1'b0, rnd_op());
    add(mk(0, 1,0,0,1,0,0,1, 0,0,0,1, 0,0,0,0), 1'b1, rnd_op());
    add(mk(1, 0,0,0,0,0,0,0, 0,0,0,3, 0,0,0,0), rnd_bit(), o);
    case (kind)
      K_LW: begin
        add(mk(2, 0,0,0,0,0,0,0, 0,0,1,2, 0,0,0,0), rnd_bit(), o);
        for (int i = 0; i < mw; i++)
          add(mk(3, 0,0,1,1,0,0,0, 0,0,0,0, 0,0,0,0), 1'b0, rnd_op());
        add(mk(3, 0,0,1,1,0,0,0, 0,0,0,0, 0,0,0,0), 1'b1, rnd_op());
        add(mk(4, 0,0,0,0,0,1,0, 0,0,0,0, 1,0,1,0), rnd_bit(), rnd_op());
      end
      K_SW: begin
        add(mk(2, 0,0,0,0,0,0,0, 0,0,1,2, 0,0,0,0), rnd_bit(), o);
        for (int i = 0; i < mw; i++)
          add(mk(5, 0,0,1,0,1,0,0, 0,0,0,0, 0,0,0,0), 1'b0, rnd_op());
        add(mk(5, 0,0,1,0,1,0,0, 0,0,0,0, 0,0,1,0), 1'b1, rnd_op());
      end
      K_R: begin
        add(mk(6, 0,0,0,0,0,0,0, 0,2,1,0, 0,0,0,0), rnd_bit(), rnd_op());
        add(mk(7, 0,0,0,0,0,0,0, 0,0,0,0, 1,1,1,0), rnd_bit(), rnd_op());
      end
      K_BEQ: add(mk(8, 0,1,0,0,0,0,0, 1,1,1,0, 0,0,1,0), rnd_bit(), rnd_op());
      K_J:   add(mk(9, 1,0,0,0,0,0,0, 2,0,0,0, 0,0,1,0), rnd_bit(), rnd_op());
      default: add(mk(10, 0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,1), rnd_bit(), rnd_op());
    endcase
  endtask

  // Replays the queued trace; inputs change just after posedge, outputs
  // are sampled at negedge.
  task automatic drain(input bit expect_retire);
    int pulses = 0;
    int cycles = 0;
    logic [21:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      mem_ready = mr_q.pop_front();
      op = op_q.pop_front();
      @(negedge clk);
      check("state", 32'(state), 32'(e[21:18]));
      check("ctrl", 32'(got_ctrl()), 32'(e[17:0]));
      check("mem_rw_excl", 32'(MemRead & MemWrite), 0);
      check("rw_pcw_excl", 32'(RegWrite & (PCWrite | PCWriteCond)), 0);
      check("done_ill_excl", 32'(instr_done & illegal_op), 0);
      pulses += int'(instr_done) + int'(illegal_op);
      cycles++;
      @(posedge clk);
      #1;
    end
    if (expect_retire) check("retire_pulses", 32'(pulses), 1);
  endtask

  task automatic run(input int kind, input int fw, input int mw);
    plan(kind, opcode_of(kind), fw, mw);
    drain(1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, 32'(state), 0);
    check({tag, "_ctrl"}, 32'(got_ctrl()), 0);
  endtask

  initial begin
    #1 rst = 1'b1;
    #2 check_all_zero("reset");
    @(posedge clk);
    #1 check_all_zero("reset_held");
    rst = 1'b0;

    // directed cases from the plan
    run(K_LW, 0, 0);
    run(K_SW, 0, 2);
    run(K_R, 0, 0);
    run(K_BEQ, 0, 0);
    run(K_J, 3, 0);
    plan(K_ILL, 6'b111111, 0, 0);
    drain(1'b1);

    // reset during MEMRD of lw: trace up to a stalled MEMRD, then reset
    add(mk(0, 1,0,0,1,0,0,1, 0,0,0,1, 0,0,0,0), 1'b1, rnd_op());
    add(mk(1, 0,0,0,0,0,0,0, 0,0,0,3, 0,0,0,0), 1'b1, 6'b100011);
    add(mk(2, 0,0,0,0,0,0,0, 0,0,1,2, 0,0,0,0), 1'b1, 6'b100011);
    add(mk(3, 0,0,1,1,0,0,0, 0,0,0,0, 0,0,0,0), 1'b0, rnd_op());
    drain(1'b0);
    mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1 check_all_zero("midreset");
    mem_ready = 1'b1;
    @(posedge clk);
    #1 check_all_zero("midreset_held");
    check("midreset_regwrite", 32'(RegWrite), 0);
    rst = 1'b0;
    run(K_LW, 1, 1);

    // random instruction mix with random stalls
    for (int n = 0; n < 60; n++) begin
      int kind = $urandom_range(0, 5);
      int fw = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      int mw = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
      run(kind, fw, mw);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Clocked control FSM that sequences the shared MIPS multicycle datapath (single memory, single ALU, IR, A/B, ALUOut and MDR registers). It supports R-type, lw, sw, beq and j, and stalls on a memory-ready handshake. It replaces the single-cycle combinational decode when the core runs in multicycle mode. The datapath registers the opcode in IR at the end of FETCH, and this block reads it from there.

## Interface
- OPCODE_WIDTH, 6, opcode field width
- STATE_WIDTH, 4, state register width
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- op  input  OPCODE_WIDTH  IR[31:26]; valid from DECODE onward
- mem_ready  input  1  memory access completes this cycle
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load if ALU zero (beq)
- IorD  output  1  0 = PC addresses memory, 1 = ALUOut addresses memory
- MemRead  output  1  memory read strobe
- MemWrite  output  1  memory write strobe
- MemtoReg  output  1  register write data from MDR
- IRWrite  output  1  load IR
- PCSource  output  2  00 = ALU, 01 = ALUOut, 10 = jump target
- ALUOp  output  2  00 = add, 01 = sub, 10 = funct decode
- ALUSrcA  output  1  0 = PC, 1 = A
- ALUSrcB  output  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- RegWrite  output  1  register file write
- RegDst  output  1  1 = rd, 0 = rt
- instr_done  output  1  one-cycle pulse when an instruction retires
- illegal_op  output  1  one-cycle pulse on an unsupported opcode
- state  output  STATE_WIDTH  current state (debug)

## Operation
- State encodings:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5
  - EXEC = 6, RCOMP = 7, BRANCH = 8, JUMP = 9, ILLEGAL = 10
- Opcodes: R = 000000, lw = 100011, sw = 101011, beq = 000100, j = 000010.
- Outputs are Moore decodes of the state, except where gated by mem_ready. Any output not listed for a state is 0.
- FETCH:
  - MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSource = 00.
  - IRWrite = PCWrite = mem_ready.
  - Stays in FETCH until mem_ready = 1, then goes to DECODE.
- DECODE:
  - ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00.
  - Next state by op: lw/sw → MEMADR; R → EXEC; beq → BRANCH; j → JUMP; any other → ILLEGAL.
- MEMADR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Goes to MEMRD if op = lw, otherwise MEMWR.
- MEMRD: MemRead = 1, IorD = 1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: RegWrite = 1, MemtoReg = 1, RegDst = 0, instr_done = 1. Goes to FETCH.
- MEMWR:
  - MemWrite = 1, IorD = 1.
  - Waits for mem_ready; instr_done = mem_ready.
  - Goes to FETCH when mem_ready = 1.
- EXEC: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10. Goes to RCOMP.
- RCOMP: RegWrite = 1, RegDst = 1, MemtoReg = 0, instr_done = 1. Goes to FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCWriteCond = 1, PCSource = 01, instr_done = 1. Goes to FETCH.
- JUMP: PCWrite = 1, PCSource = 10, instr_done = 1. Goes to FETCH.
- ILLEGAL: illegal_op = 1, no writes. Goes to FETCH; the PC has already advanced by 4.
- Unused encodings 11–15: all outputs 0, next state FETCH.
- MemRead and MemWrite are never asserted in the same cycle. RegWrite and any PC write are never asserted in the same cycle.

## Timing
- Reset:
  - rst asserted: state goes to FETCH immediately (asynchronous), and every output is forced to 0 while rst = 1 (state reads 0).
  - First FETCH decode appears in the cycle after rst deasserts.
  - Reset mid-instruction abandons the instruction; no write strobe is asserted after rst rises.
- Cycles per instruction with mem_ready held at 1: lw 5, sw 4, R 4, beq 3, j 3, illegal 3.
- Each cycle with mem_ready = 0 in FETCH, MEMRD or MEMWR adds one cycle. Strobes and address selects hold stable throughout the wait.
- mem_ready is ignored in every other state.
- instr_done and illegal_op are asserted for exactly one cycle per instruction. They are never asserted together.
- op is sampled in DECODE and MEMADR only. Changes to op at any other time have no effect.

## Test plan
- Reset then lw (op = 100011), mem_ready = 1: states 0, 1, 2, 3, 4, 0. instr_done high only in state 4; RegWrite = MemtoReg = 1 in state 4.
- sw with mem_ready low for 2 cycles in MEMWR: state 5 is held 3 cycles with MemWrite = 1 and IorD = 1. instr_done pulses on the third cycle, then FETCH.
- R-type then beq back-to-back: ALUOp = 10 in EXEC, RegDst = 1 in RCOMP; ALUOp = 01, PCWriteCond = 1, PCSource = 01 in BRANCH. Total 7 cycles.
- FETCH with mem_ready = 0 for 3 cycles: IRWrite = PCWrite = 0 throughout. On the fourth cycle mem_ready = 1 gives IRWrite = PCWrite = 1, then DECODE.
- op = 111111: states 0, 1, 10, 0. illegal_op pulses once; no RegWrite, MemWrite or PC write after FETCH.
- rst pulsed during MEMRD of lw: outputs go to 0 and state to 0 asynchronously. RegWrite is never asserted, and FETCH resumes after deassert.
